// File: rtl/fft_out_serializer.sv
// fft_out_serializer: accepts parallel 8-point complex FFT frames (Q4.12) into a
// 2-slot frame buffer and streams each frame as eight serial complex beats.
// Inverse-mode frames are scaled by 1/8 with round-half-up. Frames offered while
// both slots are full are dropped and counted in a saturating counter.
// Optional build macro FFT_BITREV_EN: beat j reads lane bitrev3(j), so a
// bit-reversed FFT output is emitted in natural bin order.
module fft_out_serializer #(
  parameter int DW     = 16,
  parameter int NPT    = 8,
  parameter int DROP_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [NPT*DW-1:0]   in_r,
  input  logic [NPT*DW-1:0]   in_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_r,
  output logic [DW-1:0]       out_i,
  output logic [2:0]          out_idx,
  output logic                out_last,
  output logic [DROP_W-1:0]   drop_cnt
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [NPT*DW-1:0]   r_slot_r [2];
  logic [NPT*DW-1:0]   r_slot_i [2];
  logic [1:0]          r_slot_mode;
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;
  logic [2:0]          r_beat;
  logic [DROP_W-1:0]   r_drop;

  logic                w_acc;
  logic                w_drop;
  logic                w_xfer;
  logic                w_done;
  logic [2:0]          w_lane;
  logic [DW-1:0]       w_raw_r;
  logic [DW-1:0]       w_raw_i;
  logic                w_mode;

  // 1/8 scaling for inverse frames: (v + 4) >>> 3 on a sign-extended copy.
  function automatic logic [DW-1:0] f_scale(input logic [DW-1:0] v, input logic m);
    logic signed [DW:0] t;
    t = {v[DW-1], v};
    t = t + (DW+1)'(4);
    t = t >>> 3;
    return m ? t[DW-1:0] : v;
  endfunction

  assign in_ready  = (r_count < 2'd2);
  assign out_valid = (r_state == S_STREAM);
  assign w_acc     = in_valid && in_ready;
  assign w_drop    = in_valid && !in_ready;
  assign w_xfer    = out_valid && out_ready;
  assign w_done    = w_xfer && (r_beat == 3'd7);

`ifdef FFT_BITREV_EN
  assign w_lane = {r_beat[0], r_beat[1], r_beat[2]};
`else
  assign w_lane = r_beat;
`endif

  // The slot under rd_ptr is never written while occupied, so outputs hold
  // steady during a stall without a separate output register stage.
  assign w_raw_r  = r_slot_r[r_rd_ptr][w_lane*DW +: DW];
  assign w_raw_i  = r_slot_i[r_rd_ptr][w_lane*DW +: DW];
  assign w_mode   = r_slot_mode[r_rd_ptr];

  assign out_r    = out_valid ? f_scale(w_raw_r, w_mode) : '0;
  assign out_i    = out_valid ? f_scale(w_raw_i, w_mode) : '0;
  assign out_idx  = r_beat;
  assign out_last = out_valid && (r_beat == 3'd7);
  assign drop_cnt = r_drop;

  // Frame storage: written on accept only; contents are meaningless while free.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_slot_r[r_wr_ptr]    <= in_r;
      r_slot_i[r_wr_ptr]    <= in_i;
      r_slot_mode[r_wr_ptr] <= in_mode;
    end
  end

  // Pointers, occupancy, beat counter and drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
      r_beat   <= '0;
      r_drop   <= '0;
    end else begin
      if (w_acc)
        r_wr_ptr <= ~r_wr_ptr;
      if (w_done)
        r_rd_ptr <= ~r_rd_ptr;
      if (w_acc && !w_done)
        r_count <= r_count + 2'd1;
      else if (!w_acc && w_done)
        r_count <= r_count - 2'd1;
      if (w_xfer)
        r_beat <= r_beat + 3'd1;
      if (w_drop && (r_drop != '1))
        r_drop <= r_drop + 1'b1;
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next state: start on accept; leave only when the last beat of the last
  // buffered frame goes out and nothing is arriving on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_acc) w_state_nxt = S_STREAM;
      S_STREAM: if (w_done && (r_count == 2'd1) && !w_acc) w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Self-checking bench for fft_out_serializer: queue-based frame model plus
// table-driven scaling vectors and hand-written corner sequences.
module tb_fft_out_serializer;
  localparam int DW     = 16;
  localparam int NPT    = 8;
  localparam int DROP_W = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic                in_mode;
  logic [NPT*DW-1:0]   in_r;
  logic [NPT*DW-1:0]   in_i;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_r;
  logic [DW-1:0]       out_i;
  logic [2:0]          out_idx;
  logic                out_last;
  logic [DROP_W-1:0]   drop_cnt;

  always #5 clk = ~clk;

  fft_out_serializer #(.DW(DW), .NPT(NPT), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_i(out_i), .out_idx(out_idx),
    .out_last(out_last), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [NPT*DW-1:0] r;
    logic [NPT*DW-1:0] i;
    logic              mode;
  } frame_t;

  typedef struct {
    logic signed [15:0] lane;
    logic signed [15:0] exp;
  } vec_t;

  frame_t      q[$];
  int unsigned m_beat;
  int unsigned m_drop;
  int          n_tests;
  int          n_fail;

  function automatic int bitrev3(int j);
    return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
  endfunction

  function automatic int lane_of(int j);
`ifdef FFT_BITREV_EN
    return bitrev3(j);
`else
    return j;
`endif
  endfunction

  // divide by 8 rounding half toward +infinity, i.e. floor((v+4)/8)
  function automatic int scale(int v, logic mode);
    int t;
    if (!mode) return v;
    t = v + 4;
    return (t >= 0) ? t / 8 : -((-t + 7) / 8);
  endfunction

  task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit vld;
    int ln;
    vld = (q.size() > 0);
    check("out_valid", out_valid, vld);
    check("in_ready", in_ready, q.size() < 2);
    check("drop_cnt", drop_cnt, m_drop);
    check("out_last", out_last, vld && (m_beat == 7));
    if (vld) begin
      ln = lane_of(m_beat);
      check("out_r", $signed(out_r), scale($signed(q[0].r[ln*16 +: 16]), q[0].mode));
      check("out_i", $signed(out_i), scale($signed(q[0].i[ln*16 +: 16]), q[0].mode));
      check("out_idx", out_idx, m_beat);
    end
  endtask

  task automatic model_edge();
    bit     rdy;
    frame_t f;
    rdy = (q.size() < 2);
    if (q.size() > 0 && out_ready) begin
      m_beat++;
      if (m_beat == 8) begin
        void'(q.pop_front());
        m_beat = 0;
      end
    end
    if (in_valid) begin
      if (rdy) begin
        f.r = in_r; f.i = in_i; f.mode = in_mode;
        q.push_back(f);
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_beat = 0;
    m_drop = 0;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic rand_frame(logic mode);
    in_r    = {$urandom, $urandom, $urandom, $urandom};
    in_i    = {$urandom, $urandom, $urandom, $urandom};
    in_mode = mode;
  endtask

  vec_t tbl[8];
  int   exp_order[8];

  initial begin
    n_tests = 0; n_fail = 0;
    model_reset();
    reset = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
    in_r = '0; in_i = '0;

    // Reset held for two cycles: everything quiet, buffer free.
    repeat (2) begin
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_ready", in_ready, 1);
      check("rst_last", out_last, 0);
      check("rst_r", out_r, 0);
      check("rst_i", out_i, 0);
      check("rst_idx", out_idx, 0);
      check("rst_drop", drop_cnt, 0);
    end
    reset = 1'b1;
    repeat (3) cyc();

    // Single forward frame, r = k*0x1000, i = -k*0x100.
    out_ready = 1'b1; in_mode = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_r[k*16 +: 16] = 16'(k * 32'h1000);
      in_i[k*16 +: 16] = 16'(-k * 32'h100);
    end
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("fwd_lat_valid", out_valid, 1);
    repeat (10) cyc();

    // Inverse scaling vectors, streamed in beat order.
    tbl[0] = '{16'sd12,     16'sd2};
    tbl[1] = '{-16'sd12,   -16'sd1};
    tbl[2] = '{16'sd32767,  16'sd4096};
    tbl[3] = '{-16'sd32768, -16'sd4096};
    tbl[4] = '{16'sd3,      16'sd0};
    tbl[5] = '{-16'sd4,     16'sd0};
    tbl[6] = '{16'sd5,      16'sd1};
    tbl[7] = '{-16'sd5,    -16'sd1};
    for (int j = 0; j < 8; j++) begin
      in_r[lane_of(j)*16 +: 16] = tbl[j].lane;
      in_i[lane_of(j)*16 +: 16] = tbl[j].lane;
    end
    in_mode = 1'b1; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check("tbl_r", $signed(out_r), tbl[j].exp);
      check("tbl_i", $signed(out_i), tbl[j].exp);
      cyc();
    end
    repeat (2) cyc();

    // Back-pressure: three frames with out_ready low; the third is dropped.
    out_ready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      rand_frame(f[0]);
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    check("bp_drop", drop_cnt, 1);
    check("bp_ready", in_ready, 0);
    out_ready = 1'b1;
    repeat (18) cyc();

    // Stall hold with out_ready toggling and sporadic frames.
    for (int c = 0; c < 60; c++) begin
      out_ready = c[0];
      in_valid  = ($urandom_range(0, 3) == 0);
      rand_frame(1'($urandom_range(0, 1)));
      cyc();
    end

    // Saturation of the drop counter.
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (300) cyc();
    check("drop_sat", drop_cnt, 255);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) cyc();

    // Reset mid-stream at beat 3.
    rand_frame(1'b0);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    check("mid_idx", out_idx, 3);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_last", out_last, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc();

    // Lane order after reset: lanes hold k.
    for (int k = 0; k < 8; k++) begin
      in_r[k*16 +: 16] = 16'(k);
      in_i[k*16 +: 16] = 16'(k);
`ifdef FFT_BITREV_EN
      exp_order[k] = bitrev3(k);
`else
      exp_order[k] = k;
`endif
    end
    in_mode = 1'b0; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check("order_r", out_r, exp_order[j]);
      cyc();
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = ($urandom_range(0, 9) < 3);
      rand_frame(1'($urandom_range(0, 1)));
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
